// File: rtl/mtr_drv.sv
// Motor-drive stage: turns signed wheel speed commands into dead-time separated
// complementary PWM pairs and latches a shutdown after persistent over-current.
module mtr_drv #(
    parameter logic [11:0] NONOVERLAP = 12'h020,
    parameter logic [11:0] BLANK      = 12'h080,
    parameter logic [4:0]  OVR_LIMIT  = 5'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        OVR_I_lft,
    input  logic        OVR_I_rght,
    output logic        PWM1_lft,
    output logic        PWM2_lft,
    output logic        PWM1_rght,
    output logic        PWM2_rght,
    output logic        OVR_I_shtdwn
);

    typedef enum logic {RUN, SHUTDOWN} state_t;

    state_t      r_state;
    logic [11:0] r_cnt;
    logic [11:0] r_dutyLft;
    logic [11:0] r_dutyRght;
    logic        r_ovrSeen;
    logic [4:0]  r_ovrCnt;

    logic        w_periodEnd;
    logic        w_ovrNow;
    logic [12:0] w_ovrStart;
    logic [12:0] w_pwm1StartLft;
    logic [12:0] w_pwm1StartRght;
    logic        w_pwm2Lft;
    logic        w_pwm1Lft;
    logic        w_pwm2Rght;
    logic        w_pwm1Rght;
    logic [4:0]  w_ovrCntNext;

    assign w_periodEnd = (r_cnt == 12'hFFF);

    // Thresholds are widened to 13 bits so a late duty pushes the PWM1 turn-on
    // point past the end of the period instead of wrapping to its start.
    assign w_ovrStart      = {1'b0, NONOVERLAP} + {1'b0, BLANK};
    assign w_pwm1StartLft  = {1'b0, r_dutyLft} + {1'b0, NONOVERLAP};
    assign w_pwm1StartRght = {1'b0, r_dutyRght} + {1'b0, NONOVERLAP};

    assign w_pwm2Lft  = (r_cnt >= NONOVERLAP) && (r_cnt < r_dutyLft);
    assign w_pwm1Lft  = ({1'b0, r_cnt} >= w_pwm1StartLft);
    assign w_pwm2Rght = (r_cnt >= NONOVERLAP) && (r_cnt < r_dutyRght);
    assign w_pwm1Rght = ({1'b0, r_cnt} >= w_pwm1StartRght);

    assign w_ovrNow = (r_state == RUN) && (OVR_I_lft || OVR_I_rght) &&
                      ({1'b0, r_cnt} >= w_ovrStart);

    always_comb begin
        w_ovrCntNext = r_ovrCnt;
        if (w_periodEnd) begin
            if (r_ovrSeen || w_ovrNow) begin
                w_ovrCntNext = (r_ovrCnt == 5'h1F) ? r_ovrCnt : r_ovrCnt + 5'd1;
            end else begin
                w_ovrCntNext = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_cnt        <= 12'h000;
            r_dutyLft    <= 12'h800;
            r_dutyRght   <= 12'h800;
            r_ovrSeen    <= 1'b0;
            r_ovrCnt     <= 5'd0;
            PWM1_lft     <= 1'b0;
            PWM2_lft     <= 1'b0;
            PWM1_rght    <= 1'b0;
            PWM2_rght    <= 1'b0;
            OVR_I_shtdwn <= 1'b0;
        end else begin
            r_cnt    <= r_cnt + 12'd1;
            r_ovrCnt <= w_ovrCntNext;

            // Duty is captured only at the period boundary; inverting the MSB
            // maps the signed speed onto an unsigned 0..FFF duty.
            if (w_periodEnd) begin
                r_dutyLft  <= {~lft_spd[11], lft_spd[10:0]};
                r_dutyRght <= {~rght_spd[11], rght_spd[10:0]};
                r_ovrSeen  <= 1'b0;
            end else if (w_ovrNow) begin
                r_ovrSeen <= 1'b1;
            end

            case (r_state)
                RUN: begin
                    PWM1_lft  <= w_pwm1Lft;
                    PWM2_lft  <= w_pwm2Lft;
                    PWM1_rght <= w_pwm1Rght;
                    PWM2_rght <= w_pwm2Rght;
                    if (w_periodEnd && (w_ovrCntNext == OVR_LIMIT)) begin
                        r_state      <= SHUTDOWN;
                        OVR_I_shtdwn <= 1'b1;
                    end
                end
                SHUTDOWN: begin
                    PWM1_lft     <= 1'b0;
                    PWM2_lft     <= 1'b0;
                    PWM1_rght    <= 1'b0;
                    PWM2_rght    <= 1'b0;
                    OVR_I_shtdwn <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: a table of per-period speed commands with hand-derived PWM
// spans, scoreboarded per period, plus shutdown and reset-recovery sequences.
module tb_mtr_drv;

    typedef struct {
        int f;
        int l;
        int n;
    } span_t;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        logic        midEn;
        logic [11:0] midLft;
        int          ovrMode;
        logic        expSh;
        span_t       p2l;
        span_t       p1l;
        span_t       p2r;
        span_t       p1r;
    } vec_t;

    localparam int NROWS = 14;

    logic        clk;
    logic        rst;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        OVR_I_lft;
    logic        OVR_I_rght;
    logic        PWM1_lft;
    logic        PWM2_lft;
    logic        PWM1_rght;
    logic        PWM2_rght;
    logic        OVR_I_shtdwn;

    logic [11:0] tcnt;
    int          nChecks;
    int          nPass;
    vec_t        rows[NROWS];
    vec_t        sb[$];

    mtr_drv #(
        .NONOVERLAP(12'h020),
        .BLANK(12'h080),
        .OVR_LIMIT(5'd4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lft_spd(lft_spd),
        .rght_spd(rght_spd),
        .OVR_I_lft(OVR_I_lft),
        .OVR_I_rght(OVR_I_rght),
        .PWM1_lft(PWM1_lft),
        .PWM2_lft(PWM2_lft),
        .PWM1_rght(PWM1_rght),
        .PWM2_rght(PWM2_rght),
        .OVR_I_shtdwn(OVR_I_shtdwn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic span_t span(input int f, input int l);
        span_t s;
        s.f = f;
        s.l = l;
        s.n = l - f + 1;
        return s;
    endfunction

    function automatic span_t none();
        span_t s;
        s.f = -1;
        s.l = -1;
        s.n = 0;
        return s;
    endfunction

    function automatic vec_t mkRow(input logic [11:0] lft, input logic [11:0] rght,
                                   input logic midEn, input logic [11:0] midLft,
                                   input int ovrMode, input logic expSh,
                                   input span_t p2l, input span_t p1l,
                                   input span_t p2r, input span_t p1r);
        vec_t v;
        v.lft = lft;
        v.rght = rght;
        v.midEn = midEn;
        v.midLft = midLft;
        v.ovrMode = ovrMode;
        v.expSh = expSh;
        v.p2l = p2l;
        v.p1l = p1l;
        v.p2r = p2r;
        v.p1r = p1r;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end else begin
            nPass++;
        end
    endtask

    task automatic checkSpan(input string name, input span_t act, input span_t exp);
        checkOutput({name, "_first"}, act.f, exp.f);
        checkOutput({name, "_last"}, act.l, exp.l);
        checkOutput({name, "_count"}, act.n, exp.n);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_PWM1_lft"}, int'(PWM1_lft), 0);
        checkOutput({tag, "_PWM2_lft"}, int'(PWM2_lft), 0);
        checkOutput({tag, "_PWM1_rght"}, int'(PWM1_rght), 0);
        checkOutput({tag, "_PWM2_rght"}, int'(PWM2_rght), 0);
        checkOutput({tag, "_shtdwn"}, int'(OVR_I_shtdwn), 0);
    endtask

    // Leaves the bench at a falling edge with the DUT counter at zero.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tcnt = 12'h000;
    endtask

    // Runs one full PWM period. Sample i observes the output registered from
    // counter value i. The next period's speeds are driven before cnt==FFF.
    task automatic applyStimulus(input int rowIdx, input vec_t cur,
                                 input logic [11:0] nL, input logic [11:0] nR,
                                 input bit doPush, input vec_t nxt);
        span_t m[4];
        int    both[2];
        logic [3:0] o;
        vec_t  exp;
        for (int k = 0; k < 4; k++) m[k] = none();
        both[0] = 0;
        both[1] = 0;
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            tcnt = tcnt + 12'd1;
            o = {PWM1_rght, PWM2_rght, PWM1_lft, PWM2_lft};
            for (int k = 0; k < 4; k++) begin
                if (o[k]) begin
                    if (m[k].n == 0) m[k].f = i;
                    m[k].l = i;
                    m[k].n++;
                end
            end
            if (o[0] && o[1]) both[0]++;
            if (o[2] && o[3]) both[1]++;
            if (i == 4095) begin
                checkOutput($sformatf("row%0d_shtdwn", rowIdx), int'(OVR_I_shtdwn), int'(cur.expSh));
            end
            OVR_I_lft  = ((cur.ovrMode == 2) && ((tcnt == 12'h030) || (tcnt == 12'h09F))) ||
                         ((cur.ovrMode == 4) && (tcnt == 12'h0A0));
            OVR_I_rght = (cur.ovrMode == 1) || ((cur.ovrMode == 3) && (tcnt == 12'hFFF));
            if (cur.midEn && (tcnt == 12'h500)) lft_spd = cur.midLft;
            if (tcnt == 12'hFFF) begin
                lft_spd  = nL;
                rght_spd = nR;
                if (doPush) sb.push_back(nxt);
            end
        end
        if (sb.size() == 0) begin
            checkOutput($sformatf("row%0d_scoreboard_empty", rowIdx), 0, 1);
        end else begin
            exp = sb.pop_front();
            checkSpan($sformatf("row%0d_PWM2_lft", rowIdx), m[0], exp.p2l);
            checkSpan($sformatf("row%0d_PWM1_lft", rowIdx), m[1], exp.p1l);
            checkSpan($sformatf("row%0d_PWM2_rght", rowIdx), m[2], exp.p2r);
            checkSpan($sformatf("row%0d_PWM1_rght", rowIdx), m[3], exp.p1r);
        end
        checkOutput($sformatf("row%0d_overlap_lft", rowIdx), both[0], 0);
        checkOutput($sformatf("row%0d_overlap_rght", rowIdx), both[1], 0);
    endtask

    initial begin
        span_t half2;
        span_t half1;
        span_t q2;
        span_t q1;
        int    badPwm;
        int    badSh;

        nChecks = 0;
        nPass = 0;
        half2 = span('h020, 'h7FF);
        half1 = span('h820, 'hFFF);
        q2 = span('h020, 'h3FF);
        q1 = span('h420, 'hFFF);

        // ovrMode: 0 none, 1 rght held, 2 lft pulses in blank window,
        // 3 rght pulse at cnt FFF only, 4 lft pulse at first unblanked count
        rows[0]  = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 2, 1'b0, half2, half1, half2, half1);
        rows[1]  = mkRow(12'h7FF, 12'h800, 1'b0, 12'h000, 2, 1'b0,
                         span('h020, 'hFFE), none(), none(), span('h020, 'hFFF));
        rows[2]  = mkRow(12'h820, 12'h821, 1'b0, 12'h000, 2, 1'b0,
                         none(), span('h040, 'hFFF), span('h020, 'h020), span('h041, 'hFFF));
        rows[3]  = mkRow(12'h7DF, 12'h7E0, 1'b0, 12'h000, 2, 1'b0,
                         span('h020, 'hFDE), span('hFFF, 'hFFF), span('h020, 'hFDF), none());
        rows[4]  = mkRow(12'h000, 12'hC00, 1'b1, 12'h400, 2, 1'b0, half2, half1, q2, q1);
        rows[5]  = mkRow(12'h400, 12'hC00, 1'b0, 12'h000, 2, 1'b0,
                         span('h020, 'hBFF), span('hC20, 'hFFF), q2, q1);
        rows[6]  = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 1, 1'b0, half2, half1, half2, half1);
        rows[7]  = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 1, 1'b0, half2, half1, half2, half1);
        rows[8]  = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 1, 1'b0, half2, half1, half2, half1);
        rows[9]  = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 0, 1'b0, half2, half1, half2, half1);
        rows[10] = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 3, 1'b0, half2, half1, half2, half1);
        rows[11] = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 4, 1'b0, half2, half1, half2, half1);
        rows[12] = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 1, 1'b0, half2, half1, half2, half1);
        rows[13] = mkRow(12'h000, 12'h000, 1'b0, 12'h000, 1, 1'b1, half2, half1, half2, half1);

        rst = 1'b1;
        lft_spd = 12'h000;
        rght_spd = 12'h000;
        OVR_I_lft = 1'b0;
        OVR_I_rght = 1'b0;
        tcnt = 12'h000;
        doReset();
        checkResetState("reset");

        sb.push_back(rows[0]);
        for (int r = 0; r < NROWS; r++) begin
            if (r + 1 < NROWS) begin
                applyStimulus(r, rows[r], rows[r + 1].lft, rows[r + 1].rght, 1'b1, rows[r + 1]);
            end else begin
                applyStimulus(r, rows[r], 12'h7FF, 12'h7FF, 1'b0, rows[0]);
            end
        end

        // Shutdown must hold every gate drive low while the counter keeps running.
        OVR_I_lft = 1'b0;
        OVR_I_rght = 1'b0;
        badPwm = 0;
        badSh = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            tcnt = tcnt + 12'd1;
            if (PWM1_lft || PWM2_lft || PWM1_rght || PWM2_rght) badPwm++;
            if (!OVR_I_shtdwn) badSh++;
        end
        checkOutput("shutdown_pwm_high_cycles", badPwm, 0);
        checkOutput("shutdown_flag_low_cycles", badSh, 0);

        // Mid-period reset with a full-scale command pending: first period
        // afterwards must still run at the reset duty of 50%.
        doReset();
        checkResetState("mid_reset");
        sb.push_back(rows[9]);
        applyStimulus(NROWS, rows[9], 12'h7FF, 12'h7FF, 1'b0, rows[9]);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
